audio_sample_pacer: RTL and testbench
=====================================

# audio_sample_pacer

Rate-pacing sample buffer directly upstream of the audio PWM stage. Accepts 8-bit unsigned audio samples from the receive path through a valid/ready handshake, stores them in a small FIFO, and releases exactly one sample per fixed sample period on `music_data`, which drives the PWM stage's `music_data` input. Pre-buffers to half-full before playback begins, and re-enters pre-buffering on underrun, so that burst delivery from the link becomes a steady sample stream.

## Interface
- `DEPTH`, 16: FIFO depth in samples; power of two, ≥4.
- `SAMPLE_DIV`, 12500: clock cycles per output sample (8 kHz at 100 MHz); must be ≥256 so every sample spans at least one full PWM period.

- `clk` input 1: 100 MHz system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset. `reset`=0 sampled at a rising edge resets the block.
- `in_data` input 8: incoming sample, unsigned, mid-scale 8'h80 = silence.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: FIFO can accept a sample this cycle. Registered.
- `music_data` output 8: current sample to the PWM stage. Registered.
- `sample_strobe` output 1: one-cycle pulse in the cycle `music_data` takes a newly popped value.
- `underrun` output 1: one-cycle pulse when a sample tick finds the FIFO empty in PLAY.
- `fill_level` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- Push: a sample is written when `in_valid`=1 and `in_ready`=1 in the same cycle. `in_data` is ignored when `in_ready`=0; the sample is not lost as long as the producer holds it.
- `in_ready` is the registered value of "occupancy after this cycle's push/pop < DEPTH". It is therefore 0 when the FIFO is full. When a pop occurs in the cycle the FIFO is full, `in_ready` is 1 on the next cycle.
- Divider: `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where `div_cnt`=SAMPLE_DIV-1. The divider runs freely in all states after reset.
- State machine, two states:
  - FILL: no pops. Moves to PLAY in the cycle after occupancy reaches ≥DEPTH/2. `music_data` holds its value.
  - PLAY: on a tick with occupancy >0, pop the head into `music_data` and pulse `sample_strobe`. On a tick with occupancy 0, pulse `underrun` and return to FILL. `music_data` on underrun depends on the Configuration section.
- Simultaneous push and pop: both happen and occupancy is unchanged. A sample pushed in the tick cycle is not eligible for that tick's pop when the FIFO was empty before that cycle.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is a separate counter that saturates structurally, because push is blocked at full and pop is blocked at empty.

## Timing
- Reset values: `music_data`=8'h80, `in_ready`=0, `sample_strobe`=0, `underrun`=0, `fill_level`=0, state=FILL, `div_cnt`=0, and both pointers 0.
- `in_ready` rises to 1 on the first cycle after `reset` returns to 1.
- Reset asserted mid-operation discards FIFO contents and returns every output to its reset value on the next edge.
- Tick to output: the popped value appears on `music_data` one cycle after the tick cycle, coincident with `sample_strobe`=1.
- Push to `fill_level`: `fill_level` reflects a push or pop one cycle after the handshake or tick.
- First audible sample after the DEPTH/2-th push: at most SAMPLE_DIV+2 cycles later.
- `music_data` changes only with `sample_strobe`, or with `underrun` when `AUDIO_PACER_UNDERRUN_MUTE_EN` is defined. It is constant for the remaining SAMPLE_DIV-1 cycles.

## Configuration
- `AUDIO_PACER_UNDERRUN_MUTE_EN`:
  - Defined: on underrun, `music_data` is set to 8'h80 in the same cycle `underrun` pulses, and holds 8'h80 through FILL until the next pop.
  - Undefined: on underrun and throughout FILL, `music_data` holds the last popped sample. The `underrun` pulse still occurs.

## Test plan
- Reset with SAMPLE_DIV=256, DEPTH=16 -> `music_data`=8'h80, `in_ready`=0 during reset, then `in_ready`=1 one cycle after release; no strobes while `fill_level`<8.
- Push 8'h10..8'h17 back-to-back -> PLAY entered; consecutive strobes exactly 256 cycles apart output 8'h10, 8'h11, … in order.
- Push 16 samples with no pops -> `in_ready`=0 and `fill_level`=16; a held `in_valid` with 8'hAA is accepted exactly one cycle after the next pop.
- Let the FIFO drain in PLAY -> `underrun` pulses on the first empty tick and state returns to FILL. With the macro, `music_data`=8'h80; without it, the last sample is held.
- Push in the tick cycle while occupancy is 1 -> the pop and push both occur and `fill_level` stays 1.
- Assert `reset`=0 mid-PLAY with 5 samples queued -> next cycle `fill_level`=0, `music_data`=8'h80, and no strobe until 8 new pushes.

Source files
------------

// File: rtl/audio_sample_pacer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_sample_pacer: FIFO that paces bursty samples out at one per SAMPLE_DIV
// cycles. Optional macro AUDIO_PACER_UNDERRUN_MUTE_EN forces mid-scale on underrun.
// Revision: 1.0
// ---------------------------------------------------------------------------
module audio_sample_pacer #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 12500
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               music_data,
  output logic                     sample_strobe,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] HALF     = CW'(DEPTH / 2);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [7:0]    mem [DEPTH];
  logic          tick, push, pop, empty_tick;

  assign tick       = (div_cnt == DIV_LAST);
  assign push       = in_valid && in_ready;
  assign fill_level = count;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    empty_tick = 1'b0;
    case (state)
      FILL: begin
        if (count >= HALF) state_next = PLAY;
      end
      PLAY: begin
        if (tick) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            empty_tick = 1'b1;
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // push is blocked at full and pop at empty, so the counter never wraps
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FILL;
      div_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_ready      <= 1'b0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      music_data    <= 8'h80;
    end else begin
      state         <= state_next;
      div_cnt       <= tick ? '0 : div_cnt + DW'(1);
      count         <= count_next;
      in_ready      <= (count_next < FULL);
      sample_strobe <= pop;
      underrun      <= empty_tick;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (pop) begin
        music_data <= mem[rd_ptr];
      end
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
      else if (empty_tick) begin
        music_data <= 8'h80;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_pacer.sv
`default_nettype none
// Directed bench for audio_sample_pacer with DEPTH=16, SAMPLE_DIV=256.
module tb_audio_sample_pacer;

  localparam int DEPTH      = 16;
  localparam int SAMPLE_DIV = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] music_data;
  logic       sample_strobe;
  logic       underrun;
  logic [4:0] fill_level;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  audio_sample_pacer #(.DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .music_data(music_data), .sample_strobe(sample_strobe),
    .underrun(underrun), .fill_level(fill_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until a strobe or underrun pulse is visible, -1 on timeout.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    forever begin
      step();
      n++;
      if (sample_strobe === 1'b1 || underrun === 1'b1) return;
      if (n >= limit) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic push_block(input logic [7:0] base, input int num);
    for (int i = 0; i < num; i++) begin
      in_data  = 8'(base + 8'(i));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) step();
    checks++; if (music_data !== 8'h80) begin fails++; $display("FAIL reset_music: got %h expected 80", music_data); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", sample_strobe); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (fill_level !== 5'd0) begin fails++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    reset = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill_play();
    int n;
    bit early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h10 + 8'(i)); in_valid = 1'b1;
      step();
      if (sample_strobe !== 1'b0) early = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (early !== 1'b0) begin fails++; $display("FAIL fill_no_strobe: got %b expected 0", early); end
    checks++; if (fill_level !== 5'd8) begin fails++; $display("FAIL fill_level8: got %0d expected 8", fill_level); end
    wait_pulse(SAMPLE_DIV + 2, n);
    checks++; if (n < 0 || sample_strobe !== 1'b1) begin fails++; $display("FAIL first_strobe: got n=%0d strobe=%b expected strobe within 258", n, sample_strobe); end
    checks++; if (music_data !== 8'h10) begin fails++; $display("FAIL first_sample: got %h expected 10", music_data); end
    for (int k = 1; k < 3; k++) begin
      wait_pulse(300, n);
      checks++; if (n !== 256) begin fails++; $display("FAIL play_gap%0d: got %0d expected 256", k, n); end
      checks++; if (music_data !== 8'(8'h10 + 8'(k))) begin fails++; $display("FAIL play_sample%0d: got %h expected %h", k, music_data, 8'(8'h10 + 8'(k))); end
    end
    checks++; if (fill_level !== 5'd5) begin fails++; $display("FAIL play_fill: got %0d expected 5", fill_level); end
  endtask

  task automatic test_full_backpressure();
    int n;
    do_reset();
    push_block(8'h20, 16);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (fill_level !== 5'd16) begin fails++; $display("FAIL full_fill: got %0d expected 16", fill_level); end
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (10) step();
    checks++; if (fill_level !== 5'd16 || in_ready !== 1'b0) begin fails++; $display("FAIL full_hold: got fill=%0d ready=%b expected 16/0", fill_level, in_ready); end
    wait_pulse(300, n);
    checks++; if (n < 0 || music_data !== 8'h20) begin fails++; $display("FAIL full_pop: got n=%0d data=%h expected data 20", n, music_data); end
    checks++; if (in_ready !== 1'b1 || fill_level !== 5'd15) begin fails++; $display("FAIL pop_reopens: got ready=%b fill=%0d expected 1/15", in_ready, fill_level); end
    step();
    in_valid = 1'b0;
    checks++; if (fill_level !== 5'd16 || in_ready !== 1'b0) begin fails++; $display("FAIL held_accept: got fill=%0d ready=%b expected 16/0", fill_level, in_ready); end
  endtask

  task automatic test_underrun();
    int n;
    logic [7:0] exp;
    for (int k = 0; k < 16; k++) begin
      exp = (k == 15) ? 8'hAA : 8'(8'h21 + 8'(k));
      wait_pulse(300, n);
      checks++; if (n !== ((k == 0) ? 255 : 256) || sample_strobe !== 1'b1 || music_data !== exp) begin
        fails++; $display("FAIL drain%0d: got n=%0d strobe=%b data=%h expected data %h", k, n, sample_strobe, music_data, exp);
      end
    end
    wait_pulse(300, n);
    checks++; if (n !== 256 || underrun !== 1'b1 || sample_strobe !== 1'b0) begin fails++; $display("FAIL underrun_pulse: got n=%0d underrun=%b strobe=%b expected 256/1/0", n, underrun, sample_strobe); end
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
    exp = 8'h80;
`else
    exp = 8'hAA;
`endif
    checks++; if (music_data !== exp) begin fails++; $display("FAIL underrun_music: got %h expected %h", music_data, exp); end
    checks++; if (fill_level !== 5'd0) begin fails++; $display("FAIL underrun_fill: got %0d expected 0", fill_level); end
    wait_pulse(300, n);
    checks++; if (n !== -1) begin fails++; $display("FAIL refill_idle: got pulse after %0d expected none", n); end
    checks++; if (music_data !== exp) begin fails++; $display("FAIL fill_hold_music: got %h expected %h", music_data, exp); end
  endtask

  task automatic test_push_in_tick();
    int n;
    push_block(8'h40, 8);
    for (int k = 0; k < 7; k++) wait_pulse(600, n);
    checks++; if (music_data !== 8'h46 || fill_level !== 5'd1) begin fails++; $display("FAIL pre_tick: got data=%h fill=%0d expected 46/1", music_data, fill_level); end
    repeat (255) step();
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (sample_strobe !== 1'b1 || music_data !== 8'h47) begin fails++; $display("FAIL tick_pop: got strobe=%b data=%h expected 1/47", sample_strobe, music_data); end
    checks++; if (fill_level !== 5'd1) begin fails++; $display("FAIL tick_fill: got %0d expected 1", fill_level); end
    wait_pulse(300, n);
    checks++; if (n !== 256 || music_data !== 8'h5A || fill_level !== 5'd0) begin fails++; $display("FAIL tick_push_out: got n=%0d data=%h fill=%0d expected 256/5a/0", n, music_data, fill_level); end
  endtask

  task automatic test_reset_mid_play();
    int n;
    do_reset();
    push_block(8'h30, 8);
    for (int k = 0; k < 3; k++) wait_pulse(600, n);
    checks++; if (fill_level !== 5'd5 || music_data !== 8'h32) begin fails++; $display("FAIL mid_pre: got fill=%0d data=%h expected 5/32", fill_level, music_data); end
    reset = 1'b0;
    step();
    checks++; if (fill_level !== 5'd0 || music_data !== 8'h80) begin fails++; $display("FAIL mid_reset: got fill=%0d data=%h expected 0/80", fill_level, music_data); end
    checks++; if (sample_strobe !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ctl: got strobe=%b ready=%b expected 0/0", sample_strobe, in_ready); end
    reset = 1'b1;
    step();
    push_block(8'h60, 7);
    wait_pulse(600, n);
    checks++; if (n !== -1) begin fails++; $display("FAIL seven_no_play: got pulse after %0d expected none", n); end
    push_block(8'h67, 1);
    wait_pulse(SAMPLE_DIV + 2, n);
    checks++; if (n < 0 || sample_strobe !== 1'b1 || music_data !== 8'h60) begin fails++; $display("FAIL restart_play: got n=%0d strobe=%b data=%h expected strobe with 60", n, sample_strobe, music_data); end
  endtask

  initial begin
    test_reset();
    test_fill_play();
    test_full_backpressure();
    test_underrun();
    test_push_in_tick();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
